// File: rtl/cu_multicycle_if.sv
// ---------------------------------------------------------------------------
// cu_multicycle_if
//   Signal bundle between the multicycle control unit and its datapath and
//   memories.
//
//   Handshakes:
//     instr/im_valid : instr is consumed by the control unit in the FETCH
//                      cycle in which im_valid=1 (ir_we pulses in that same
//                      cycle). im_valid is ignored in every other state.
//     dm_en/dm_ready : dm_en stays high for the whole MEM stay. The access
//                      completes in the first MEM cycle with dm_ready=1.
//                      dm_ready is ignored while dm_en=0.
//
//   Modports:
//     master : datapath / memory side. Drives the instruction word,
//              handshakes and branch result. Receives all control outputs.
//     slave  : control-unit side (cu_multicycle).
// ---------------------------------------------------------------------------
interface cu_multicycle_if #(
    parameter int CNT_W = 32
);
    // Datapath / memory -> control unit
    logic [31:0]      instr;
    logic             im_valid;
    logic             dm_ready;
    logic             branch_taken;

    // Control unit -> datapath / memory
    logic             ir_we;
    logic             pc_we;
    logic             pc_src;
    logic             rf_we;
    logic             dm_en;
    logic             dm_we;
    logic [2:0]       dm_ctrl;
    logic [1:0]       sel_op1;
    logic             sel_op2;
    logic [1:0]       sel_wb;
    logic [2:0]       alu_func3;
    logic             alu_subsra;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [4:0]       rd;
    logic [2:0]       state;
    logic             trap;
    logic [CNT_W-1:0] instret;

    modport master (
        output instr, im_valid, dm_ready, branch_taken,
        input  ir_we, pc_we, pc_src, rf_we, dm_en, dm_we, dm_ctrl,
               sel_op1, sel_op2, sel_wb, alu_func3, alu_subsra,
               rs1, rs2, rd, state, trap, instret
    );

    modport slave (
        input  instr, im_valid, dm_ready, branch_taken,
        output ir_we, pc_we, pc_src, rf_we, dm_en, dm_we, dm_ctrl,
               sel_op1, sel_op2, sel_wb, alu_func3, alu_subsra,
               rs1, rs2, rd, state, trap, instret
    );
endinterface

// File: rtl/cu_multicycle.sv
// ---------------------------------------------------------------------------
// cu_multicycle
//   Multicycle RV32-style control unit. Instructions are captured into an
//   internal IR and then sequenced through FETCH -> DECODE -> EXEC ->
//   (MEM) -> (WB). Unsupported opcodes and data-memory timeouts park the FSM
//   in TRAP until reset. Retired instructions are counted in instret.
//
//   Ports:
//     clk    : single clock, rising edge
//     reset  : synchronous, active-high
//     bus    : cu_multicycle_if.slave
//              in : instr, im_valid, dm_ready, branch_taken
//              out: ir_we, pc_we, pc_src, rf_we, dm_en, dm_we, dm_ctrl,
//                   sel_op1, sel_op2, sel_wb, alu_func3, alu_subsra,
//                   rs1, rs2, rd, state, trap, instret
//
//   Parameters:
//     CNT_W   : instret width; the counter wraps silently.
//     TIMEOUT : MEM cycles with dm_ready=0 tolerated before trapping.
//               Must be at least 1.
// ---------------------------------------------------------------------------
module cu_multicycle #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 15
) (
    input logic            clk,
    input logic            reset,
    cu_multicycle_if.slave bus
);

    // wait_q only needs to reach TIMEOUT-1.
    localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    localparam logic [6:0] OP_NOP    = 7'b0000000;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       ir_q, ir_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  instret_q, instret_d;

    // -----------------------------------------------------------------------
    // IR field decode. Everything below depends on ir_q only.
    // -----------------------------------------------------------------------
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       is_nop, is_r, is_i, is_load, is_store, is_branch;
    logic       is_jalr, is_jal, is_lui, is_auipc, is_legal;

    assign opcode    = ir_q[6:0];
    assign funct3    = ir_q[14:12];
    assign is_nop    = (opcode == OP_NOP);
    assign is_r      = (opcode == OP_R);
    assign is_i      = (opcode == OP_I);
    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);
    assign is_branch = (opcode == OP_BRANCH);
    assign is_jalr   = (opcode == OP_JALR);
    assign is_jal    = (opcode == OP_JAL);
    assign is_lui    = (opcode == OP_LUI);
    assign is_auipc  = (opcode == OP_AUIPC);
    assign is_legal  = is_r | is_i | is_load | is_store | is_branch |
                       is_jalr | is_jal | is_lui | is_auipc;

    logic [1:0] sel_op1_c;
    logic       sel_op2_c;
    logic [1:0] sel_wb_c;
    logic [2:0] alu_func3_c;
    logic       alu_subsra_c;
    logic [4:0] rs2_c;
    logic [4:0] rd_c;

    always_comb begin
        sel_op1_c    = 2'b01;
        sel_op2_c    = 1'b1;
        sel_wb_c     = 2'b01;
        alu_func3_c  = 3'b000;
        alu_subsra_c = 1'b0;
        rs2_c        = ir_q[24:20];
        rd_c         = ir_q[11:7];

        unique case (1'b1)
            is_r: begin
                sel_op2_c    = 1'b0;
                alu_func3_c  = funct3;
                alu_subsra_c = ir_q[30];
            end
            is_i: begin
                alu_func3_c  = funct3;
                // Only SRAI uses bit 30; for other I-ops it is immediate data.
                alu_subsra_c = (funct3 == 3'b101) ? ir_q[30] : 1'b0;
                rs2_c        = 5'd0;
            end
            is_load: begin
                sel_wb_c = 2'b00;
                rs2_c    = 5'd0;
            end
            is_store: begin
                rd_c = 5'd0;
            end
            is_branch: begin
                sel_op1_c = 2'b00;
                rd_c      = 5'd0;
            end
            is_jalr: begin
                sel_wb_c = 2'b10;
                rs2_c    = 5'd0;
            end
            is_jal: begin
                sel_op1_c = 2'b00;
                sel_wb_c  = 2'b10;
                rs2_c     = 5'd0;
            end
            is_lui: begin
                sel_op1_c = 2'b10;
                rs2_c     = 5'd0;
            end
            is_auipc: begin
                sel_op1_c = 2'b00;
                rs2_c     = 5'd0;
            end
            default: ;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM next-state and strobes
    // -----------------------------------------------------------------------
    logic ir_we_c, pc_we_c, pc_src_c, rf_we_c, dm_en_c, dm_we_c, retire;

    always_comb begin
        state_d  = state_q;
        ir_d     = ir_q;
        wait_d   = wait_q;
        ir_we_c  = 1'b0;
        pc_we_c  = 1'b0;
        pc_src_c = 1'b0;
        rf_we_c  = 1'b0;
        dm_en_c  = 1'b0;
        dm_we_c  = 1'b0;
        retire   = 1'b0;

        unique case (state_q)
            FETCH: begin
                if (bus.im_valid) begin
                    ir_we_c = 1'b1;
                    ir_d    = bus.instr;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (is_nop) begin
                    pc_we_c = 1'b1;
                    retire  = 1'b1;
                    state_d = FETCH;
                end else if (!is_legal) begin
                    state_d = TRAP;
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (is_load || is_store) begin
                    wait_d  = '0;
                    state_d = MEM;
                end else if (is_branch) begin
                    pc_we_c  = 1'b1;
                    pc_src_c = bus.branch_taken;
                    retire   = 1'b1;
                    state_d  = FETCH;
                end else begin
                    state_d = WB;
                end
            end
            MEM: begin
                dm_en_c = 1'b1;
                dm_we_c = is_store;
                if (bus.dm_ready) begin
                    if (is_store) begin
                        pc_we_c = 1'b1;
                        retire  = 1'b1;
                        state_d = FETCH;
                    end else begin
                        state_d = WB;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    // This is the TIMEOUT-th cycle without dm_ready.
                    state_d = TRAP;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            WB: begin
                rf_we_c  = (rd_c != 5'd0);
                pc_we_c  = 1'b1;
                pc_src_c = is_jal | is_jalr;
                retire   = 1'b1;
                state_d  = FETCH;
            end
            TRAP: begin
                state_d = TRAP;
            end
            default: begin
                // Unused encodings can only come from a corrupted register.
                state_d = TRAP;
            end
        endcase
    end

    assign instret_d = instret_q + (retire ? CNT_W'(1) : CNT_W'(0));

    // -----------------------------------------------------------------------
    // State registers. Reset wins over any transition or retirement.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FETCH;
            ir_q      <= '0;
            wait_q    <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            wait_q    <= wait_d;
            instret_q <= instret_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs. Strobes are forced low while reset is held so that no side
    // effect escapes in the reset cycle.
    // -----------------------------------------------------------------------
    assign bus.ir_we      = ir_we_c & ~reset;
    assign bus.pc_we      = pc_we_c & ~reset;
    assign bus.pc_src     = pc_src_c;
    assign bus.rf_we      = rf_we_c & ~reset;
    assign bus.dm_en      = dm_en_c & ~reset;
    assign bus.dm_we      = dm_we_c & ~reset;
    assign bus.dm_ctrl    = funct3;
    assign bus.sel_op1    = sel_op1_c;
    assign bus.sel_op2    = sel_op2_c;
    assign bus.sel_wb     = sel_wb_c;
    assign bus.alu_func3  = alu_func3_c;
    assign bus.alu_subsra = alu_subsra_c;
    assign bus.rs1        = ir_q[19:15];
    assign bus.rs2        = rs2_c;
    assign bus.rd         = rd_c;
    assign bus.state      = state_q;
    assign bus.trap       = (state_q == TRAP);
    assign bus.instret    = instret_q;

endmodule
